// File: rtl/cnn_pkg.sv
// Shared types, sizes and helpers for the conv1d CFU post-processing path.
// Pool/channel normalisation lives here so config decode stays in one place.
package cnn_pkg;

  localparam int BYTE_SIZE    = 8;
  localparam int INT32_SIZE   = 32;
  localparam int MAX_CHANNELS = 128;
  localparam int MAX_POOL     = 4;
  localparam int FIFO_DEPTH   = 16;

  localparam int CH_W   = $clog2(MAX_CHANNELS + 1);
  localparam int POOL_W = $clog2(MAX_POOL + 1);
  localparam int ADDR_W = $clog2(MAX_CHANNELS);
  localparam int LANES  = INT32_SIZE / BYTE_SIZE;
  localparam int LANE_W = $clog2(LANES);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  typedef logic signed [BYTE_SIZE-1:0] int8_t;

  typedef struct packed {
    logic                  last;
    logic [INT32_SIZE-1:0] data;
  } word_t;

  // Ties keep the stored value.
  function automatic int8_t smax8(input int8_t stored, input int8_t cand);
    return (cand > stored) ? cand : stored;
  endfunction

  function automatic logic [CH_W-1:0] norm_ch(input logic [7:0] c);
    if (c == 8'd0)
      return CH_W'(1);
    if (c > 8'(MAX_CHANNELS))
      return CH_W'(MAX_CHANNELS);
    return CH_W'(c);
  endfunction

  function automatic logic [POOL_W-1:0] norm_pool(input logic [2:0] p);
    if (p == 3'd0)
      return POOL_W'(1);
    if (p > 3'(MAX_POOL))
      return POOL_W'(MAX_POOL);
    return POOL_W'(p);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with occupancy count.
// Head reads as zero while empty so the output bus is clean after reset.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic          valid_o,
  output logic [CW-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign valid_o = (cnt_q != '0);
  assign do_push = push_i && (cnt_q != CW'(DEPTH));
  assign do_pop  = pop_i && valid_o;
  assign dout_o  = valid_o ? mem[rd_q] : '0;
  assign count_o = cnt_q;

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_q] <= din_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push)
        wr_q <= wr_q + AW'(1);
      if (do_pop)
        rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/maxpool1d_packer.sv
// 1D max-pool along x over channel-major int8 conv outputs,
// packing pooled bytes four per word into an output FIFO.
module maxpool1d_packer
  import cnn_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [7:0]            cfg_channels,
  input  logic [2:0]            cfg_pool,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BYTE_SIZE-1:0]  in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INT32_SIZE-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);

  logic [CH_W-1:0]       chan_q;
  logic [POOL_W-1:0]     pool_q;
  logic [CH_W-1:0]       ch_idx_q;
  logic [POOL_W-1:0]     pool_idx_q;
  logic [LANE_W-1:0]     lane_q;
  logic [INT32_SIZE-1:0] word_q;
  int8_t                 max_ram [MAX_CHANNELS];

  logic [CH_W-1:0]       chan_d;
  logic [POOL_W-1:0]     pool_d;
  logic [ADDR_W-1:0]     addr;
  int8_t                 stored;
  int8_t                 mx;
  logic [INT32_SIZE-1:0] word_d;
  logic                  acc;
  logic                  ch_end;
  logic                  pool_end;
  logic                  emit;
  logic                  flush;
  word_t                 fifo_din;
  word_t                 fifo_dout;
  logic [CNT_W-1:0]      fifo_cnt;

  assign busy = (ch_idx_q != '0) | (pool_idx_q != '0)
              | (lane_q != '0) | (fifo_cnt != '0);

  // One free slot is always kept for the word a byte may complete.
  assign in_ready = (fifo_cnt <= CNT_W'(FIFO_DEPTH - 2));
  assign acc      = in_valid & in_ready;

  always_comb begin
    chan_d   = chan_q;
    pool_d   = pool_q;
    if (cfg_we && !busy) begin
      chan_d = norm_ch(cfg_channels);
      pool_d = norm_pool(cfg_pool);
    end
    addr     = ch_idx_q[ADDR_W-1:0];
    stored   = max_ram[addr];
    mx       = (pool_idx_q == '0) ? int8_t'(in_data)
                                  : smax8(stored, int8_t'(in_data));
    ch_end   = (ch_idx_q == chan_d - CH_W'(1));
    pool_end = (pool_idx_q == pool_d - POOL_W'(1));
    emit     = acc & pool_end;
    flush    = emit & ((lane_q == LANE_W'(LANES - 1)) | ch_end);
    word_d   = word_q;
    word_d[lane_q*BYTE_SIZE +: BYTE_SIZE] = mx;
    fifo_din = '{last: ch_end, data: word_d};
  end

  always_ff @(posedge clk) begin
    if (acc)
      max_ram[addr] <= mx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chan_q     <= CH_W'(1);
      pool_q     <= POOL_W'(1);
      ch_idx_q   <= '0;
      pool_idx_q <= '0;
      lane_q     <= '0;
      word_q     <= '0;
    end else begin
      chan_q <= chan_d;
      pool_q <= pool_d;
      if (acc) begin
        if (ch_end) begin
          ch_idx_q   <= '0;
          pool_idx_q <= pool_end ? '0 : pool_idx_q + POOL_W'(1);
        end else begin
          ch_idx_q   <= ch_idx_q + CH_W'(1);
        end
      end
      if (emit) begin
        if (flush) begin
          lane_q <= '0;
          word_q <= '0;
        end else begin
          lane_q <= lane_q + LANE_W'(1);
          word_q <= word_d;
        end
      end
    end
  end

  sync_fifo #(
    .W     ($bits(word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (flush),
    .din_i   (fifo_din),
    .pop_i   (out_ready),
    .dout_o  (fifo_dout),
    .valid_o (out_valid),
    .count_o (fifo_cnt)
  );

  assign out_data = fifo_dout.data;
  assign out_last = fifo_dout.last;

endmodule

// File: tb/tb_maxpool1d_packer.sv
// Scoreboard bench for maxpool1d_packer: expected words queued at drive time,
// compared as the FIFO head is popped.
module tb_maxpool1d_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [7:0]  cfg_channels;
  logic [2:0]  cfg_pool;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;

  int nchk = 0;
  int nerr = 0;
  logic [32:0] sb [$];

  logic [7:0] t1 [8] = '{8'h01, 8'hFB, 8'h07, 8'h80,
                         8'h03, 8'hFA, 8'h07, 8'h7F};

  always #5 clk = ~clk;

  maxpool1d_packer dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_we       (cfg_we),
    .cfg_channels (cfg_channels),
    .cfg_pool     (cfg_pool),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [32:0] exp;
    if (!rst && out_valid && out_ready) begin
      exp = (sb.size() != 0) ? sb.pop_front() : 33'h1_DEAD_BEEF;
      check("out_word", {31'b0, out_last, out_data}, {31'b0, exp});
    end
  end

  task automatic cfg(input logic [7:0] ch, input logic [2:0] pl);
    cfg_we       = 1'b1;
    cfg_channels = ch;
    cfg_pool     = pl;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    bit ok = 0;
    in_valid = 1'b1;
    in_data  = b;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    check("accept", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_cfg(input logic [7:0] b, input logic [7:0] ch,
                          input logic [2:0] pl);
    cfg_we       = 1'b1;
    cfg_channels = ch;
    cfg_pool     = pl;
    send(b);
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    out_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) begin
        ok = 1;
        break;
      end
    end
    check("drain", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    rst          = 1'b1;
    cfg_we       = 1'b0;
    cfg_channels = 8'd0;
    cfg_pool     = 3'd0;
    in_valid     = 1'b0;
    in_data      = 8'd0;
    out_ready    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // channels=4, pool=2 with latency check
    out_ready = 1'b0;
    cfg(8'd4, 3'd2);
    sb.push_back({1'b1, 32'h7F07FB03});
    for (int i = 0; i < 7; i++) send(t1[i]);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_no_early", 64'(out_valid), 64'd0);
    send(t1[7]);
    check("t1_latency", 64'(out_valid), 64'd1);
    drain();
    check("t1_idle", 64'(busy), 64'd0);

    // channels=6, pool=1: partial upper word
    cfg(8'd6, 3'd1);
    sb.push_back({1'b0, 32'h04030201});
    sb.push_back({1'b1, 32'h00000605});
    for (int i = 1; i <= 6; i++) send(8'(i));
    drain();

    // backpressure and simultaneous push/pop
    out_ready = 1'b0;
    cfg(8'd8, 3'd1);
    for (int k = 0; k < 16; k++) begin
      w = {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
      sb.push_back({1'(k % 2), w});
    end
    for (int i = 0; i < 56; i++) send(8'(i + 1));
    check("bp_ready_14", 64'(in_ready), 64'd1);
    for (int i = 56; i < 60; i++) send(8'(i + 1));
    check("bp_ready_drop", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_ready_pop", 64'(in_ready), 64'd1);
    for (int i = 60; i < 63; i++) send(8'(i + 1));
    out_ready = 1'b1;
    send(8'd64);
    out_ready = 1'b0;
    check("pushpop_ready", 64'(in_ready), 64'd1);
    check("pushpop_valid", 64'(out_valid), 64'd1);
    drain();

    // reset mid-row
    cfg(8'd4, 3'd2);
    for (int i = 0; i < 3; i++) send(t1[i]);
    check("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cfg(8'd4, 3'd2);
    sb.push_back({1'b1, 32'h7F07FB03});
    for (int i = 0; i < 8; i++) send(t1[i]);
    drain();

    // cfg ignored while busy
    cfg(8'd4, 3'd2);
    sb.push_back({1'b1, 32'h7F07FB03});
    send(t1[0]);
    send(t1[1]);
    cfg(8'd2, 3'd1);
    for (int i = 2; i < 8; i++) send(t1[i]);
    drain();

    // pool 0 acts as 1, applied to the same-cycle byte
    sb.push_back({1'b1, 32'h00002010});
    send_cfg(8'h10, 8'd2, 3'd0);
    send(8'h20);
    drain();

    // pool 7 clamps to 4
    sb.push_back({1'b1, 32'h00000009});
    send_cfg(8'h05, 8'd1, 3'd7);
    send(8'hFD);
    send(8'h09);
    check("pool_clamp_wait", 64'(out_valid), 64'd0);
    send(8'h02);
    check("pool_clamp_emit", 64'(out_valid), 64'd1);
    drain();
    check("final_idle", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
